// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus widths, access-size
// selects and the arbiter FSM state encoding.
package mem_bus_arbiter_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the MEM stage and the 32-bit bus: store lane
// placement and write enables, load byte extraction with sign/zero extension.
module mem_lane_align
    import mem_bus_arbiter_pkg::*;
(
    input  logic [3:0]          i_sel,
    input  logic [1:0]          i_addr_lo,
    input  logic                i_sign_ext,
    input  logic [DATA_BUS-1:0] i_wdata,
    input  logic [DATA_BUS-1:0] i_rdata,
    output logic [3:0]          o_wen,
    output logic [DATA_BUS-1:0] o_wdata,
    output logic [DATA_BUS-1:0] o_rdata
);

    logic [1:0] w_lane;
    logic [7:0] w_byte;

    // Word accesses always use lane 0; low address bits are not meaningful.
    assign w_lane  = (i_sel == SEL_WORD) ? 2'b00 : i_addr_lo;
    assign o_wen   = i_sel << w_lane;
    assign o_wdata = (i_sel == SEL_BYTE) ? {4{i_wdata[7:0]}} : i_wdata;
    assign w_byte  = i_rdata[{w_lane, 3'b000} +: 8];
    assign o_rdata = (i_sel == SEL_BYTE) ? {{24{i_sign_ext & w_byte[7]}}, w_byte}
                                         : i_rdata;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single SRAM-style bus between instruction fetch and MEM-stage
// loads/stores (MEM has priority). Define MEM_ALIGN_CHECK_EN to reject misaligned word accesses.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_BUS-1:0] if_addr,
    output logic                if_ready,
    output logic [DATA_BUS-1:0] if_rdata,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_sign_ext,
    input  logic [3:0]          mem_sel,
    input  logic [ADDR_BUS-1:0] mem_addr,
    input  logic [DATA_BUS-1:0] mem_wdata,
    output logic                mem_ready,
    output logic [DATA_BUS-1:0] mem_rdata,
    output logic                mem_addr_err,
    output logic                stall_req,
    output logic                bus_en,
    output logic [3:0]          bus_wen,
    output logic [ADDR_BUS-1:0] bus_addr,
    output logic [DATA_BUS-1:0] bus_wdata,
    input  logic [DATA_BUS-1:0] bus_rdata,
    input  logic                bus_ack
);

    localparam logic [ADDR_BUS-1:0] WORD_MASK = ~32'h3;

    state_t              r_state, w_state_next;
    logic                r_grant_mem, w_grant_mem_next;
    logic                r_bus_en, w_bus_en_next;
    logic [3:0]          r_bus_wen, w_bus_wen_next;
    logic [ADDR_BUS-1:0] r_bus_addr, w_bus_addr_next;
    logic [DATA_BUS-1:0] r_bus_wdata, w_bus_wdata_next;
    logic                r_if_ready, w_if_ready_next;
    logic [DATA_BUS-1:0] r_if_rdata, w_if_rdata_next;
    logic                r_mem_ready, w_mem_ready_next;
    logic [DATA_BUS-1:0] r_mem_rdata, w_mem_rdata_next;
    logic                r_mem_addr_err, w_mem_addr_err_next;

    logic [3:0]          w_lane_wen;
    logic [DATA_BUS-1:0] w_lane_wdata;
    logic [DATA_BUS-1:0] w_lane_rdata;
    logic                w_misalign;

    mem_lane_align u_lane_align (
        .i_sel      (mem_sel),
        .i_addr_lo  (mem_addr[1:0]),
        .i_sign_ext (mem_sign_ext),
        .i_wdata    (mem_wdata),
        .i_rdata    (bus_rdata),
        .o_wen      (w_lane_wen),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_lane_rdata)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (mem_sel == SEL_WORD) && (mem_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next        = r_state;
        w_grant_mem_next    = r_grant_mem;
        w_bus_en_next       = r_bus_en;
        w_bus_wen_next      = r_bus_wen;
        w_bus_addr_next     = r_bus_addr;
        w_bus_wdata_next    = r_bus_wdata;
        w_if_ready_next     = 1'b0;
        w_if_rdata_next     = r_if_rdata;
        w_mem_ready_next    = 1'b0;
        w_mem_rdata_next    = r_mem_rdata;
        w_mem_addr_err_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_read | mem_write) begin
                    w_grant_mem_next = 1'b1;
                    if (w_misalign) begin
                        w_state_next        = ST_DONE;
                        w_mem_ready_next    = 1'b1;
                        w_mem_addr_err_next = 1'b1;
                        w_mem_rdata_next    = '0;
                    end else begin
                        w_state_next     = ST_BUSY;
                        w_bus_en_next    = 1'b1;
                        w_bus_wen_next   = mem_write ? w_lane_wen : 4'b0000;
                        w_bus_addr_next  = mem_addr & WORD_MASK;
                        w_bus_wdata_next = mem_write ? w_lane_wdata : '0;
                    end
                end else if (if_req) begin
                    w_grant_mem_next = 1'b0;
                    w_state_next     = ST_BUSY;
                    w_bus_en_next    = 1'b1;
                    w_bus_wen_next   = 4'b0000;
                    w_bus_addr_next  = if_addr & WORD_MASK;
                    w_bus_wdata_next = '0;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    w_state_next   = ST_DONE;
                    w_bus_en_next  = 1'b0;
                    w_bus_wen_next = 4'b0000;
                    if (r_grant_mem) begin
                        w_mem_ready_next = 1'b1;
                        w_mem_rdata_next = w_lane_rdata;
                    end else begin
                        w_if_ready_next  = 1'b1;
                        w_if_rdata_next  = bus_rdata;
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_grant_mem    <= 1'b0;
            r_bus_en       <= 1'b0;
            r_bus_wen      <= 4'b0000;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_if_ready     <= 1'b0;
            r_if_rdata     <= '0;
            r_mem_ready    <= 1'b0;
            r_mem_rdata    <= '0;
            r_mem_addr_err <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_grant_mem    <= w_grant_mem_next;
            r_bus_en       <= w_bus_en_next;
            r_bus_wen      <= w_bus_wen_next;
            r_bus_addr     <= w_bus_addr_next;
            r_bus_wdata    <= w_bus_wdata_next;
            r_if_ready     <= w_if_ready_next;
            r_if_rdata     <= w_if_rdata_next;
            r_mem_ready    <= w_mem_ready_next;
            r_mem_rdata    <= w_mem_rdata_next;
            r_mem_addr_err <= w_mem_addr_err_next;
        end
    end

    assign bus_en       = r_bus_en;
    assign bus_wen      = r_bus_wen;
    assign bus_addr     = r_bus_addr;
    assign bus_wdata    = r_bus_wdata;
    assign if_ready     = r_if_ready;
    assign if_rdata     = r_if_rdata;
    assign mem_ready    = r_mem_ready;
    assign mem_rdata    = r_mem_rdata;
    assign mem_addr_err = r_mem_addr_err;
    // Gated by reset so every output reads 0 while reset is held.
    assign stall_req    = (if_req | mem_read | mem_write) & ~(r_if_ready | r_mem_ready) & rst;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the core's single SRAM-style memory port between instruction fetch (IF) and the MEM-stage load/store path. It sequences each access with a request/acknowledge handshake and stalls the pipeline until the data returns. It performs byte-lane placement for stores and byte extraction with sign or zero extension for loads. It sits between the IF/MEM stages and the external bus, and consumes the read/write/sign-extend/select/write-data controls that decode produces.

## Interface
- No parameters; widths come from shared bus definitions (ADDR_BUS = 32, DATA_BUS = 32).
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_ready`
- `if_addr`  in  32  fetch address, word-aligned
- `if_ready`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  32  fetched word
- `mem_read`, `mem_write`  in  1 each  load/store request; at most one high; held until `mem_ready`
- `mem_sign_ext`  in  1  sign-extend a loaded byte
- `mem_sel`  in  4  0001 = byte, 1111 = word
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  store data (byte in [7:0])
- `mem_ready`  out  1  one-cycle pulse; access complete
- `mem_rdata`  out  32  aligned, extended load result
- `mem_addr_err`  out  1  pulses with `mem_ready` on a rejected access (only when the macro is defined)
- `stall_req`  out  1  a pending request has not completed
- `bus_en`  out  1  bus access valid
- `bus_wen`  out  4  byte write enables; 0000 = read
- `bus_addr`  out  32  word address, `[1:0]` = 00
- `bus_wdata`  out  32  lane-placed store data
- `bus_rdata`  in  32  read data, valid with `bus_ack`
- `bus_ack`  in  1  slave completes the access this cycle

## Operation
- FSM states:
  - IDLE: grant MEM if `mem_read|mem_write`, else grant IF if `if_req`. Go to BUSY and register the bus outputs.
  - BUSY: hold `bus_*` stable. On `bus_ack`, capture the read data and go to DONE.
  - DONE: pulse the granted side's ready. No new grant this cycle. Go to IDLE.
- Fixed priority: MEM wins simultaneous requests. IF is served on the next IDLE.
- Store lanes:
  - `bus_wen = mem_sel << mem_addr[1:0]`.
  - Byte store replicates `mem_wdata[7:0]` into all four lanes.
  - Word store passes `mem_wdata` through.
- Load byte: take lane `mem_addr[1:0]` of `bus_rdata`. Sign-extend if `mem_sign_ext`, else zero-extend. Word load passes through.
- IF accesses are always word reads (`bus_wen` = 0000).
- `stall_req = (if_req | mem_read | mem_write) & ~(if_ready | mem_ready)`.
- `rst` low, at any point including mid-access: state goes to IDLE. All outputs go to 0 immediately; the bus access is abandoned.

## Timing
- Reset values: `bus_en`, `bus_wen`, `bus_addr`, `bus_wdata`, `if_ready`, `if_rdata`, `mem_ready`, `mem_rdata`, `mem_addr_err` are all 0.
- Request seen in IDLE at cycle N:
  - `bus_en` = 1 in N+1.
  - If `bus_ack` arrives in cycle M ≥ N+1, ready pulses in M+1.
  - `bus_en` drops in M+1.
- Minimum access is 3 cycles, request to next grant.
- `bus_ack` while not BUSY is ignored.
- `bus_*` outputs, ready pulses and read data are registered. `stall_req` is combinational.
- Requesters deassert or advance on the edge ending the ready cycle. A request held into the IDLE cycle after DONE is treated as new.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A word access with `mem_addr[1:0]` ≠ 00 issues no bus cycle.
  - IDLE → DONE, with `mem_ready` = 1, `mem_addr_err` = 1 and `mem_rdata` = 0 one cycle later.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `mem_addr[1:0]` is ignored for word accesses; the access is issued at `{addr[31:2],2'b00}`.
  - `mem_addr_err` is tied to 0.

## Structure
- Shared header: FSM state encodings (IDLE/BUSY/DONE), the `mem_sel` constants `SEL_BYTE` = 0001 and `SEL_WORD` = 1111, and the bus-width defines.
- One sub-module, `mem_lane_align`: combinational store lane placement, `bus_wen` generation, and load byte extraction/extension. The arbiter instantiates it once.

## Test plan
- Reset asserted mid-BUSY (`bus_en` = 1): all outputs are 0 at once. After release, no ready pulse and state is IDLE.
- IF read 0x0000_0040, ack after 2 wait cycles returning 0x2402_0005: `bus_wen` = 0000, `if_ready` pulses with `if_rdata` = 0x2402_0005, `stall_req` = 1 until the pulse.
- Simultaneous `if_req` and SB to 0x103 with data 0x0000_00A5: MEM granted first with `bus_wen` = 1000 and `bus_wdata` = 0xA5A5_A5A5. IF is issued in the following IDLE.
- LB at 0x101 with `bus_rdata` = 0x1234_8056: `mem_rdata` = 0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SW to 0x200 with data 0xDEAD_BEEF and ack in the same cycle as `bus_en`: `bus_wen` = 1111, `mem_ready` in the next cycle, total 3 cycles.
- LW at 0x202 with the macro defined: no `bus_en`, `mem_ready` and `mem_addr_err` pulse 1 cycle after grant. Without the macro: bus access at 0x200.
